// File: rtl/fp_mul_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// flag bit positions, operand classes and the exponent bias helper.
package fp_mul_pkg;

  // Bit positions inside the 3-bit flags word {nv, ovf, unf}
  localparam int FLG_NV  = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  // Operand classes. Denormals are classified as zero; NaN shares the inf class.
  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2
  } op_cls_e;

  // Exponent bias for a given exponent field width: 2^(exp_w-1)-1
  function automatic int unsigned exp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_norm_round.sv
// fp_norm_round: final multiplier stage, purely combinational.
// Normalises the raw mantissa product, rounds, range-checks and packs.
// Macro FP_MUL_RNE_EN: when defined, round-to-nearest-even; otherwise the
// result is truncated and no rounding adder exists.
module fp_norm_round
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                    i_sign,
  input  logic signed [EXP_W+1:0] i_exp,
  input  op_cls_e                 i_cls_a,
  input  op_cls_e                 i_cls_b,
  input  logic [2*MAN_W+1:0]      i_mprod,
  output logic [EXP_W+MAN_W:0]    o_product,
  output logic [2:0]              o_flags
);

  localparam int PW = 2*MAN_W+2;
  localparam logic signed [EXP_W+1:0] EXP_ONE  = $signed({{(EXP_W+1){1'b0}}, 1'b1});
  localparam logic signed [EXP_W+1:0] EXP_MAX  = $signed({2'b00, {EXP_W{1'b1}}});
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;

  logic                    w_man_msb;
  logic [MAN_W-1:0]        w_man;
  logic                    w_guard;
  logic                    w_sticky;
  logic signed [EXP_W+1:0] w_exp_n;
  logic [MAN_W-1:0]        w_man_r;
  logic signed [EXP_W+1:0] w_exp_r;
  logic                    w_a_zero;
  logic                    w_b_zero;
  logic                    w_a_inf;
  logic                    w_b_inf;

  assign w_man_msb = i_mprod[PW-1];

  // Normalise: product lies in [1,4); a set MSB means one extra exponent step
  always_comb begin
    if (w_man_msb) begin
      w_man    = i_mprod[PW-2 -: MAN_W];
      w_guard  = i_mprod[MAN_W];
      w_sticky = |i_mprod[MAN_W-1:0];
      w_exp_n  = i_exp + EXP_ONE;
    end else begin
      w_man    = i_mprod[PW-3 -: MAN_W];
      w_guard  = i_mprod[MAN_W-1];
      w_sticky = |i_mprod[MAN_W-2:0];
      w_exp_n  = i_exp;
    end
  end

`ifdef FP_MUL_RNE_EN
  // Round to nearest even; a carry out of the mantissa bumps the exponent
  logic             w_rnd_up;
  logic [MAN_W:0]   w_man_sum;
  assign w_rnd_up  = w_guard & (w_sticky | w_man[0]);
  assign w_man_sum = {1'b0, w_man} + {{MAN_W{1'b0}}, w_rnd_up};
  assign w_man_r   = w_man_sum[MAN_W-1:0];
  assign w_exp_r   = w_man_sum[MAN_W] ? (w_exp_n + EXP_ONE) : w_exp_n;
`else
  // Truncation: discarded bits are dropped
  logic w_unused_round;
  assign w_unused_round = w_guard ^ w_sticky;
  assign w_man_r = w_man;
  assign w_exp_r = w_exp_n;
`endif

  assign w_a_zero = (i_cls_a == CLS_ZERO);
  assign w_b_zero = (i_cls_b == CLS_ZERO);
  assign w_a_inf  = (i_cls_a == CLS_INF);
  assign w_b_inf  = (i_cls_b == CLS_INF);

  // Special operands first, then range checks on the rounded exponent, then pack
  always_comb begin
    o_flags   = '0;
    o_product = {i_sign, w_exp_r[EXP_W-1:0], w_man_r};
    if ((w_a_zero && w_b_inf) || (w_a_inf && w_b_zero)) begin
      o_product        = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      o_flags[FLG_NV]  = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      o_product = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_a_zero || w_b_zero) begin
      o_product = {i_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (w_exp_r >= EXP_MAX) begin
      o_product        = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_flags[FLG_OVF] = 1'b1;
    end else if (w_exp_r <= EXP_ZERO) begin
      o_product        = {i_sign, {(EXP_W+MAN_W){1'b0}}};
      o_flags[FLG_UNF] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: fully pipelined floating-point multiplier with tag sideband.
// Registers: S1 (unpacked operands), S2 (mantissa product), S3 (packed result),
// then the output register. Macro FP_MUL_RNE_EN selects round-to-nearest-even
// inside fp_norm_round; without it results are truncated.
// Handshake: a transfer happens on a cycle where valid && ready; while
// out_valid && !out_ready every output holds and no input is accepted.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   product,
  output logic [TAG_W-1:0]       out_tag,
  output logic [2:0]             flags
);

  localparam int W  = 1+EXP_W+MAN_W;
  localparam int PW = 2*MAN_W+2;
  localparam logic [EXP_W+1:0] BIAS_X = (EXP_W+2)'(exp_bias(EXP_W));

  logic                    w_en;
  logic [EXP_W-1:0]        w_exp_a;
  logic [EXP_W-1:0]        w_exp_b;
  logic signed [EXP_W+1:0] w_exp_sum;
  logic [PW-1:0]           w_mprod;
  logic [W-1:0]            w_s3_product;
  logic [2:0]              w_s3_flags;

  logic                    r_s1_valid, r_s2_valid, r_s3_valid, r_out_valid;
  logic                    r_s1_sign, r_s2_sign;
  logic signed [EXP_W+1:0] r_s1_exp, r_s2_exp;
  op_cls_e                 r_s1_cls_a, r_s1_cls_b, r_s2_cls_a, r_s2_cls_b;
  logic [MAN_W:0]          r_s1_man_a, r_s1_man_b;
  logic [PW-1:0]           r_s2_mprod;
  logic [TAG_W-1:0]        r_s1_tag, r_s2_tag, r_s3_tag, r_out_tag;
  logic [W-1:0]            r_s3_product, r_product;
  logic [2:0]              r_s3_flags, r_flags;

  function automatic op_cls_e classify(input logic [EXP_W-1:0] e);
    if (e == '0) return CLS_ZERO;
    if (&e)      return CLS_INF;
    return CLS_NORM;
  endfunction

  // Whole pipeline advances together unless a held result is waiting
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  assign w_exp_a   = a[W-2 -: EXP_W];
  assign w_exp_b   = b[W-2 -: EXP_W];
  assign w_exp_sum = $signed({2'b00, w_exp_a} + {2'b00, w_exp_b} - BIAS_X);
  assign w_mprod   = {{(MAN_W+1){1'b0}}, r_s1_man_a} * {{(MAN_W+1){1'b0}}, r_s1_man_b};

  fp_norm_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_norm_round (
    .i_sign    (r_s2_sign),
    .i_exp     (r_s2_exp),
    .i_cls_a   (r_s2_cls_a),
    .i_cls_b   (r_s2_cls_b),
    .i_mprod   (r_s2_mprod),
    .o_product (w_s3_product),
    .o_flags   (w_s3_flags)
  );

  // Valid bits and visible outputs: cleared asynchronously, shifted on enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_product   <= '0;
      r_flags     <= '0;
      r_out_tag   <= '0;
    end else if (w_en) begin
      r_s1_valid  <= in_valid;
      r_s2_valid  <= r_s1_valid;
      r_s3_valid  <= r_s2_valid;
      r_out_valid <= r_s3_valid;
      if (r_s3_valid) begin
        r_product <= r_s3_product;
        r_flags   <= r_s3_flags;
        r_out_tag <= r_s3_tag;
      end
    end
  end

  // Internal datapath registers: contents only matter when their valid bit is set
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_s1_sign    <= a[W-1] ^ b[W-1];
      r_s1_exp     <= w_exp_sum;
      r_s1_cls_a   <= classify(w_exp_a);
      r_s1_cls_b   <= classify(w_exp_b);
      r_s1_man_a   <= {1'b1, a[MAN_W-1:0]};
      r_s1_man_b   <= {1'b1, b[MAN_W-1:0]};
      r_s1_tag     <= in_tag;
      r_s2_sign    <= r_s1_sign;
      r_s2_exp     <= r_s1_exp;
      r_s2_cls_a   <= r_s1_cls_a;
      r_s2_cls_b   <= r_s1_cls_b;
      r_s2_mprod   <= w_mprod;
      r_s2_tag     <= r_s1_tag;
      r_s3_product <= w_s3_product;
      r_s3_flags   <= w_s3_flags;
      r_s3_tag     <= r_s2_tag;
    end
  end

  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign flags     = r_flags;
  assign out_tag   = r_out_tag;

endmodule
